// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the
// system ID control slave (1-bit word address, 32-bit readdata).
interface niosii_system_sysid_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (output address, output read, input waitrequest, input readdata);
  modport slave  (input address, input read, output waitrequest, output readdata);
endinterface

// File: rtl/niosii_system_sysid_checker.sv
// Reads system ID (addr 0) and build timestamp (addr 1) from the sysid slave
// on request, compares both against expected values and flags stalls.
//
// state  | meaning
// IDLE   | waiting for start, results cleared by reset only
// RD_ID  | read strobe on address 0 until accepted or timed out
// LAT_ID | waiting READ_LATENCY cycles for ID readdata
// RD_TS  | read strobe on address 1 until accepted or timed out
// LAT_TS | waiting READ_LATENCY cycles for timestamp readdata
// DONE   | results valid and held until the next start
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1393789890,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 start,
  niosii_system_sysid_checker_if.master        avm,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 id_ok,
  output logic                                 ts_ok,
  output logic                                 timeout,
  output logic [31:0]                          id_value,
  output logic [31:0]                          ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE} state_t;

  // Both timers are down-counters; terminal count is zero.
  localparam logic [15:0] STALL_LOAD = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAT_LOAD   = 3'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [2:0]  lat_q, lat_d;
  logic        addr_q, addr_d;
  logic [31:0] id_d, ts_d;
  logic        id_ok_d, ts_ok_d, timeout_d;
  logic        cap;

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    id_d      = id_value;
    ts_d      = ts_value;
    id_ok_d   = id_ok;
    ts_ok_d   = ts_ok;
    timeout_d = timeout;
    cap       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RD_ID;
          addr_d    = 1'b0;
          stall_d   = STALL_LOAD;
          id_d      = '0;
          ts_d      = '0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      RD_ID, RD_TS: begin
        if (!avm.waitrequest) begin
          if (READ_LATENCY == 0) begin
            cap = 1'b1;
          end else begin
            state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
            lat_d   = LAT_LOAD;
          end
        end else if (stall_q == '0) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
        end else begin
          stall_d = stall_q - 16'd1;
        end
      end
      LAT_ID, LAT_TS: begin
        if (lat_q == '0) cap = 1'b1;
        else             lat_d = lat_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase

    // ID capture chains straight into the timestamp read; timestamp capture finishes.
    if (cap) begin
      if (state_q == RD_ID || state_q == LAT_ID) begin
        id_d    = avm.readdata;
        state_d = RD_TS;
        addr_d  = 1'b1;
        stall_d = STALL_LOAD;
      end else begin
        ts_d    = avm.readdata;
        state_d = DONE;
        id_ok_d = (id_value == EXPECTED_ID);
        ts_ok_d = (avm.readdata == EXPECTED_TIMESTAMP);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      stall_q  <= '0;
      lat_q    <= '0;
      addr_q   <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      id_value <= id_d;
      ts_value <= ts_d;
      id_ok    <= id_ok_d;
      ts_ok    <= ts_ok_d;
      timeout  <= timeout_d;
    end
  end

  assign avm.read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign avm.address = addr_q;
  assign busy        = (state_q == RD_ID) || (state_q == LAT_ID) ||
                       (state_q == RD_TS) || (state_q == LAT_TS);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench: three checker instances (default, short timeout, latency 2)
// share clock/reset/start, each with its own sysid slave model.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] TS_WORD = 32'd1393789890;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] id_word = 32'h0;
  logic [31:0] ts_word = TS_WORD;
  int          stall_n [3] = '{0, 0, 0};

  logic        busy [3], done [3], id_ok [3], ts_ok [3], timeout [3];
  logic [31:0] id_value [3], ts_value [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  niosii_system_sysid_checker_if avm [3] ();

  niosii_system_sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(avm[0]),
    .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
    .timeout(timeout[0]), .id_value(id_value[0]), .ts_value(ts_value[0]));

  niosii_system_sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(4)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(avm[1]),
    .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
    .timeout(timeout[1]), .id_value(id_value[1]), .ts_value(ts_value[1]));

  niosii_system_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(avm[2]),
    .busy(busy[2]), .done(done[2]), .id_ok(id_ok[2]), .ts_ok(ts_ok[2]),
    .timeout(timeout[2]), .id_value(id_value[2]), .ts_value(ts_value[2]));

  // Slave models: stall the first stall_n cycles of each read, return data
  // LAT cycles after acceptance, garbage otherwise.
  for (genvar g = 0; g < 3; g++) begin : g_slv
    localparam int LAT = (g == 2) ? 2 : 0;
    int   wcnt = 0;
    int   lcnt = 0;
    logic laddr = 1'b0;

    assign avm[g].waitrequest = avm[g].read && (wcnt < stall_n[g]);
    assign avm[g].readdata = (LAT == 0) ? (avm[g].address ? ts_word : id_word)
                           : ((lcnt == 1) ? (laddr ? ts_word : id_word) : 32'hDEAD_BEEF);

    always @(posedge clock) begin
      if (!avm[g].read)           wcnt <= 0;
      else if (avm[g].waitrequest) wcnt <= wcnt + 1;
      else                        wcnt <= 0;
      if (avm[g].read && !avm[g].waitrequest) begin
        lcnt  <= LAT;
        laddr <= avm[g].address;
      end else if (lcnt > 0) begin
        lcnt <= lcnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Start high during cycle 0; returns at the sample point of cycle 1.
  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    reset_n = 1'b1;
    step(1);
    chk("rst_busy", {31'b0, busy[0]}, 32'd0);
    chk("rst_done", {31'b0, done[0]}, 32'd0);
    chk("rst_read", {31'b0, avm[0].read}, 32'd0);
    chk("rst_addr", {31'b0, avm[0].address}, 32'd0);
    chk("rst_idv", id_value[0], 32'd0);

    // 1: zero-wait, back-to-back reads
    pulse_start();
    chk("t1_c1_read", {31'b0, avm[0].read}, 32'd1);
    chk("t1_c1_addr", {31'b0, avm[0].address}, 32'd0);
    chk("t1_c1_busy", {31'b0, busy[0]}, 32'd1);
    step(1);
    chk("t1_c2_read", {31'b0, avm[0].read}, 32'd1);
    chk("t1_c2_addr", {31'b0, avm[0].address}, 32'd1);
    step(1);
    chk("t1_done", {31'b0, done[0]}, 32'd1);
    chk("t1_busy", {31'b0, busy[0]}, 32'd0);
    chk("t1_read", {31'b0, avm[0].read}, 32'd0);
    chk("t1_id_ok", {31'b0, id_ok[0]}, 32'd1);
    chk("t1_ts_ok", {31'b0, ts_ok[0]}, 32'd1);
    chk("t1_tsv", ts_value[0], 32'd1393789890);
    step(10);

    // 2: wrong ID word
    id_word = 32'h0000_0001;
    pulse_start();
    step(2);
    chk("t2_done", {31'b0, done[0]}, 32'd1);
    chk("t2_id_ok", {31'b0, id_ok[0]}, 32'd0);
    chk("t2_ts_ok", {31'b0, ts_ok[0]}, 32'd1);
    chk("t2_idv", id_value[0], 32'd1);
    step(10);

    // 3: five stall cycles per read
    id_word = 32'h0;
    stall_n[0] = 5;
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("t3_c%0d_read", c), {31'b0, avm[0].read}, 32'd1);
      chk($sformatf("t3_c%0d_addr", c), {31'b0, avm[0].address}, (c <= 6) ? 32'd0 : 32'd1);
      step(1);
    end
    chk("t3_done", {31'b0, done[0]}, 32'd1);
    chk("t3_id_ok", {31'b0, id_ok[0]}, 32'd1);
    chk("t3_ts_ok", {31'b0, ts_ok[0]}, 32'd1);
    chk("t3_timeout", {31'b0, timeout[0]}, 32'd0);
    stall_n[0] = 0;
    step(10);

    // 4: stuck waitrequest, TIMEOUT_CYCLES=4
    stall_n[1] = 1000;
    pulse_start();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t4_c%0d_read", c), {31'b0, avm[1].read}, 32'd1);
      step(1);
    end
    chk("t4_read", {31'b0, avm[1].read}, 32'd0);
    chk("t4_done", {31'b0, done[1]}, 32'd1);
    chk("t4_timeout", {31'b0, timeout[1]}, 32'd1);
    chk("t4_id_ok", {31'b0, id_ok[1]}, 32'd0);
    chk("t4_ts_ok", {31'b0, ts_ok[1]}, 32'd0);
    chk("t4_idv", id_value[1], 32'd0);
    chk("t4_addr", {31'b0, avm[1].address}, 32'd0);
    stall_n[1] = 0;
    step(10);

    // 5: READ_LATENCY=2
    pulse_start();
    chk("t5_c1_read", {31'b0, avm[2].read}, 32'd1);
    step(1);
    chk("t5_c2_read", {31'b0, avm[2].read}, 32'd0);
    step(1);
    chk("t5_c3_read", {31'b0, avm[2].read}, 32'd0);
    step(1);
    chk("t5_c4_read", {31'b0, avm[2].read}, 32'd1);
    chk("t5_c4_addr", {31'b0, avm[2].address}, 32'd1);
    step(1);
    chk("t5_c5_read", {31'b0, avm[2].read}, 32'd0);
    step(2);
    chk("t5_done", {31'b0, done[2]}, 32'd1);
    chk("t5_id_ok", {31'b0, id_ok[2]}, 32'd1);
    chk("t5_ts_ok", {31'b0, ts_ok[2]}, 32'd1);
    chk("t5_idv", id_value[2], 32'd0);
    chk("t5_tsv", ts_value[2], 32'd1393789890);
    step(10);

    // 6: start while busy ignored, mid-read reset, clean rerun
    stall_n[0] = 5;
    pulse_start();
    step(7);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t6_ign_addr", {31'b0, avm[0].address}, 32'd1);
    chk("t6_ign_read", {31'b0, avm[0].read}, 32'd1);
    step(4);
    chk("t6_ign_done", {31'b0, done[0]}, 32'd1);
    step(5);

    id_word = 32'h0000_0001;
    pulse_start();
    step(7);
    chk("t6_pre_idv", id_value[0], 32'd1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("t6_rst_busy", {31'b0, busy[0]}, 32'd0);
    chk("t6_rst_done", {31'b0, done[0]}, 32'd0);
    chk("t6_rst_read", {31'b0, avm[0].read}, 32'd0);
    chk("t6_rst_addr", {31'b0, avm[0].address}, 32'd0);
    chk("t6_rst_idv", id_value[0], 32'd0);
    chk("t6_rst_ok", {30'b0, id_ok[0], ts_ok[0]}, 32'd0);
    chk("t6_rst_to", {31'b0, timeout[0]}, 32'd0);
    step(3);

    id_word = 32'h0;
    stall_n[0] = 0;
    pulse_start();
    step(2);
    chk("t6_done", {31'b0, done[0]}, 32'd1);
    chk("t6_id_ok", {31'b0, id_ok[0]}, 32'd1);
    chk("t6_ts_ok", {31'b0, ts_ok[0]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
